// File: rtl/uart_loop_ctrl.sv
`timescale 1ns/1ps
// uart_loop_ctrl: picks the shared baud divider, buffers uart_rx bytes in a FIFO
// and replays them through uart_tx in arrival order.
module uart_loop_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 50000000,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            baud_sel,
    input  logic                  rx_busy,
    input  logic                  rx_done,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  tx_busy,
    output logic                  tx_en,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic [15:0]           uart_cnt,
    output logic [ADDR_W:0]       fifo_cnt,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic                  tx_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(FIFO_DEPTH);
    localparam logic [1:0]      WAIT_LAST = 2'd3;

    function automatic logic [15:0] baud_div(input logic [1:0] sel);
        case (sel)
            2'd0:    return 16'(CLK_FREQ / 9600);
            2'd1:    return 16'(CLK_FREQ / 19200);
            2'd2:    return 16'(CLK_FREQ / 57600);
            default: return 16'(CLK_FREQ / 115200);
        endcase
    endfunction

    state_t                state, state_nxt;
    logic [1:0]            wait_cnt, wait_cnt_nxt;
    logic                  pop;
    logic                  timeout_set;
    logic [1:0]            baud_sel_p0;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
    logic                  full;
    logic                  push;
    logic                  drop;
    logic                  baud_ok;

    // A full FIFO still takes the byte when LOAD frees a slot in the same cycle.
    assign full    = (fifo_cnt == DEPTH_CNT);
    assign push    = rx_done && (!full || pop);
    assign drop    = rx_done && full && !pop;
    assign baud_ok = (state == IDLE) && (fifo_cnt == '0) && !rx_busy && !tx_busy;
    assign tx_en   = (state == START);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        pop          = 1'b0;
        timeout_set  = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_cnt != '0 && !tx_busy) state_nxt = LOAD;
            end
            LOAD: begin
                pop       = 1'b1;
                state_nxt = START;
            end
            START: begin
                wait_cnt_nxt = '0;
                state_nxt    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_set = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 2'd1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: FSM, FIFO bookkeeping and registered baud selection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            baud_sel_p0 <= 2'd3;
            uart_cnt    <= baud_div(2'd3);
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            overflow    <= 1'b0;
            tx_timeout  <= 1'b0;
            tx_data     <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            baud_sel_p0 <= baud_sel;
            tx_timeout  <= timeout_set;
            if (baud_ok) uart_cnt <= baud_div(baud_sel_p0);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                tx_data <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (drop) overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_data;
    end

endmodule

// File: tb/tb_uart_loop_ctrl.sv
`timescale 1ns/1ps
// Directed bench for uart_loop_ctrl: a per-cycle vector table for the basic
// loopback and timeout paths, plus scripted sequences for FIFO, baud and reset corners.
module tb_uart_loop_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] baud_sel;
    logic       rx_busy;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_en;
    logic [7:0] tx_data;
    logic [15:0] uart_cnt;
    logic [4:0] fifo_cnt;
    logic       overflow;
    logic       ovf_clr;
    logic       tx_timeout;

    int n_vec = 0;
    int n_bad = 0;

    uart_loop_ctrl dut (
        .clk(clk), .rst_n(rst_n), .baud_sel(baud_sel), .rx_busy(rx_busy),
        .rx_done(rx_done), .rx_data(rx_data), .tx_busy(tx_busy), .tx_en(tx_en),
        .tx_data(tx_data), .uart_cnt(uart_cnt), .fifo_cnt(fifo_cnt),
        .overflow(overflow), .ovf_clr(ovf_clr), .tx_timeout(tx_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rx_done;
        logic [7:0] rx_data;
        logic       tx_busy;
        logic       en;
        logic [7:0] data;
        logic [4:0] cnt;
        logic       ovf;
        logic       to;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rx_done  = 1'b0;
        rx_data  = 8'h00;
        rx_busy  = 1'b0;
        tx_busy  = 1'b0;
        ovf_clr  = 1'b0;
        baud_sel = 2'd3;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_tx_en();
        for (int k = 0; k < 12 && tx_en !== 1'b1; k++) step();
    endtask

    task automatic serve(input logic [7:0] exp, input string nm);
        wait_tx_en();
        chk({nm, ".tx_en"}, tx_en, 1);
        chk({nm, ".tx_data"}, tx_data, exp);
        tx_busy = 1'b1;
        step();
        step();
        tx_busy = 1'b0;
        step();
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation exceeded its time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        //          rx  data   busy en  data   cnt  ovf  to
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 5'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 5'd0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 5'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 5'd0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 5'd0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 5'd0, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 8'h5A, 1'b0, 1'b0, 8'h3C, 5'd1, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 5'd1, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 5'd0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 5'd0, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 5'd0, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 5'd0, 1'b0, 1'b0};

        do_reset();
        chk("rst.tx_en", tx_en, 0);
        chk("rst.tx_data", tx_data, 0);
        chk("rst.fifo_cnt", fifo_cnt, 0);
        chk("rst.overflow", overflow, 0);
        chk("rst.tx_timeout", tx_timeout, 0);
        chk("rst.uart_cnt", uart_cnt, 434);

        // Single byte loopback, then a start that uart_tx never acknowledges.
        for (int i = 0; i < 21; i++) begin
            rx_done = vecs[i].rx_done;
            rx_data = vecs[i].rx_data;
            tx_busy = vecs[i].tx_busy;
            step();
            chk($sformatf("v%0d.tx_en", i), tx_en, vecs[i].en);
            chk($sformatf("v%0d.tx_data", i), tx_data, vecs[i].data);
            chk($sformatf("v%0d.fifo_cnt", i), fifo_cnt, vecs[i].cnt);
            chk($sformatf("v%0d.overflow", i), overflow, vecs[i].ovf);
            chk($sformatf("v%0d.tx_timeout", i), tx_timeout, vecs[i].to);
            chk($sformatf("v%0d.uart_cnt", i), uart_cnt, 434);
        end
        rx_done = 1'b0;
        tx_busy = 1'b0;

        // Burst of 20 into a blocked transmitter: saturate, overflow, clear, drain in order.
        do_reset();
        tx_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rx_done = 1'b1;
            rx_data = 8'h10 + 8'(i);
            step();
        end
        rx_done = 1'b0;
        chk("burst.fifo_cnt", fifo_cnt, 16);
        chk("burst.overflow", overflow, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("burst.ovf_clr", overflow, 0);
        rx_done = 1'b1;
        rx_data = 8'hEE;
        ovf_clr = 1'b1;
        step();
        rx_done = 1'b0;
        ovf_clr = 1'b0;
        chk("burst.set_wins", overflow, 1);
        chk("burst.drop_cnt", fifo_cnt, 16);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        tx_busy = 1'b0;
        for (int i = 0; i < 16; i++) serve(8'h10 + 8'(i), $sformatf("burst.b%0d", i));
        chk("burst.empty", fifo_cnt, 0);
        chk("burst.ovf_after", overflow, 0);

        // Push coinciding with the LOAD pop on a full FIFO.
        do_reset();
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_done = 1'b1;
            rx_data = 8'h40 + 8'(i);
            step();
        end
        rx_done = 1'b0;
        chk("full.fifo_cnt", fifo_cnt, 16);
        tx_busy = 1'b0;
        step();
        rx_done = 1'b1;
        rx_data = 8'h99;
        step();
        rx_done = 1'b0;
        chk("full.start", tx_en, 1);
        chk("full.fifo_cnt_hold", fifo_cnt, 16);
        chk("full.no_overflow", overflow, 0);
        for (int i = 0; i < 16; i++) serve(8'h40 + 8'(i), $sformatf("full.b%0d", i));
        serve(8'h99, "full.late");
        chk("full.empty", fifo_cnt, 0);

        // Baud change held off while either PHY is busy.
        tx_busy  = 1'b1;
        baud_sel = 2'd0;
        repeat (3) step();
        chk("baud.pending_tx", uart_cnt, 434);
        tx_busy = 1'b0;
        repeat (2) step();
        chk("baud.9600", uart_cnt, 5208);
        baud_sel = 2'd1;
        rx_busy  = 1'b1;
        repeat (3) step();
        chk("baud.pending_rx", uart_cnt, 5208);
        rx_busy = 1'b0;
        repeat (2) step();
        chk("baud.19200", uart_cnt, 2604);
        baud_sel = 2'd2;
        repeat (2) step();
        chk("baud.57600", uart_cnt, 868);

        // Reset during WAIT_DONE with five bytes queued.
        baud_sel = 2'd0;
        repeat (2) step();
        chk("mid.uart_cnt", uart_cnt, 5208);
        rx_done = 1'b1;
        rx_data = 8'h77;
        step();
        rx_done = 1'b0;
        wait_tx_en();
        chk("mid.start", tx_en, 1);
        tx_busy = 1'b1;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            rx_done = 1'b1;
            rx_data = 8'hC0 + 8'(i);
            step();
        end
        rx_done = 1'b0;
        chk("mid.queued", fifo_cnt, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.rst_fifo_cnt", fifo_cnt, 0);
        chk("mid.rst_tx_en", tx_en, 0);
        chk("mid.rst_uart_cnt", uart_cnt, 434);
        chk("mid.rst_tx_data", tx_data, 0);
        repeat (2) @(posedge clk);
        #1;
        baud_sel = 2'd3;
        tx_busy  = 1'b0;
        rst_n    = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (tx_en === 1'b1) seen++;
        end
        chk("mid.discarded", seen, 0);

        // tx_en drops as soon as reset asserts, without waiting for a clock.
        rx_done = 1'b1;
        rx_data = 8'h81;
        step();
        rx_done = 1'b0;
        wait_tx_en();
        chk("async.start", tx_en, 1);
        chk("async.tx_data", tx_data, 8'h81);
        #2 rst_n = 1'b0;
        #1;
        chk("async.tx_en", tx_en, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
